// File: rtl/stack_xfer_seq.sv
// stack_xfer_seq: sequences multi-register stack push/pull transfers over a req/ack memory port
module stack_xfer_seq #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        is_pull,
  input  logic        stack_s,
  input  logic [7:0]  postbyte,
  input  logic [15:0] reg_su,
  input  logic [15:0] path_left_data,
  output logic [3:0]  path_left_addr,
  output logic        use_s,
  output logic        dec_su,
  output logic        inc_su,
  output logic        write_reg,
  output logic [3:0]  write_reg_addr,
  output logic [15:0] data_w,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, SCAN, DEC, WR, RD, INC, WB, FIN} state_t;
  state_t state, state_n;
  logic [7:0] mask;
  logic [2:0] cur, pick;
  logic [3:0] code;
  logic [15:0] hold;
  logic [31:0] timer;
  logic pull, second, wide, more, timeout;
  always_comb begin
    pick = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!pull && mask[3'(i)]) pick = 3'(i);
      if (pull && mask[3'(7 - i)]) pick = 3'(7 - i);
    end
  end
  always_comb begin
    code = cur == 3'd7 ? 4'd5 :
           cur == 3'd6 ? (use_s ? 4'd3 : 4'd4) :
           cur == 3'd5 ? 4'd2 :
           cur == 3'd4 ? 4'd1 :
           cur == 3'd3 ? 4'd11 :
           cur == 3'd2 ? 4'd9 :
           cur == 3'd1 ? 4'd8 : 4'd10;
    wide = cur[2];
    more = wide && !second;
    timeout = (ACK_TIMEOUT > 0) && mem_req && !mem_ack && timer == 32'(ACK_TIMEOUT - 1);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SCAN : IDLE;
      SCAN: state_n = mask == 8'h00 ? FIN : pull ? RD : DEC;
      DEC:  state_n = WR;
      WR:   state_n = timeout ? IDLE : mem_ack ? (more ? DEC : SCAN) : WR;
      RD:   state_n = timeout ? IDLE : mem_ack ? INC : RD;
      INC:  state_n = more ? RD : WB;
      WB:   state_n = SCAN;
      FIN:  state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    dec_su = state == DEC;
    inc_su = state == INC;
    mem_req = state == WR || state == RD;
    mem_we = state == WR;
    mem_addr = mem_req ? reg_su : 16'h0000;
    mem_wdata = mem_we ? (second ? path_left_data[15:8] : path_left_data[7:0]) : 8'h00;
    path_left_addr = (state == DEC || state == WR) ? code : 4'd0;
    write_reg = state == WB;
    write_reg_addr = write_reg ? code : 4'd0;
    data_w = write_reg ? hold : 16'h0000;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      mask <= 8'h00;
      pull <= 1'b0;
      use_s <= 1'b0;
      cur <= 3'd0;
      second <= 1'b0;
      hold <= 16'h0000;
      timer <= 32'd0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == FIN;
      err <= timeout;
      timer <= (mem_req && !mem_ack) ? timer + 32'd1 : 32'd0;
      if (state == IDLE && start) begin
        mask <= postbyte;
        pull <= is_pull;
        use_s <= stack_s;
      end
      if (state == SCAN) begin
        cur <= pick;
        second <= 1'b0;
        hold <= 16'h0000;
        mask[pick] <= 1'b0;
      end
      if (((state == WR && mem_ack) || state == INC) && wide) second <= 1'b1;
      if (state == RD && mem_ack) begin
        if (more) hold[15:8] <= mem_rdata;
        else hold[7:0] <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_stack_xfer_seq.sv
// tb_stack_xfer_seq: randomized self-checking bench for stack_xfer_seq against a transfer-level model
module tb_stack_xfer_seq;
  logic clk_in = 0, reset = 1, start = 0, is_pull = 0, stack_s = 0, mem_ack = 0;
  logic [7:0] postbyte = 0, mem_rdata = 0, mem_wdata;
  logic [15:0] sp = 0, reg_su, path_left_data, data_w, mem_addr;
  logic [3:0] path_left_addr, write_reg_addr;
  logic use_s, dec_su, inc_su, write_reg, mem_req, mem_we, busy, done, err;
  logic [15:0] regs [16];
  logic [7:0] mem [65536];
  logic [23:0] wlog [$];
  logic [19:0] rlog [$];
  logic [24:0] snap;
  logic [56:0] outs;
  bit silent = 0, inreq = 0;
  int dmin = 0, dmax = 0, wcnt = 0, dly = 0;
  int n_dec = 0, n_inc = 0, n_done = 0, n_req = 0, n_checks = 0, n_pass = 0;

  assign reg_su = sp;
  assign path_left_data = regs[path_left_addr];
  assign outs = {path_left_addr, use_s, dec_su, inc_su, write_reg, write_reg_addr, data_w,
                 mem_req, mem_we, mem_addr, mem_wdata, busy, done, err};

  always #5 clk_in = ~clk_in;

  stack_xfer_seq #(.ACK_TIMEOUT(8)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .is_pull(is_pull), .stack_s(stack_s),
    .postbyte(postbyte), .reg_su(reg_su), .path_left_data(path_left_data),
    .path_left_addr(path_left_addr), .use_s(use_s), .dec_su(dec_su), .inc_su(inc_su),
    .write_reg(write_reg), .write_reg_addr(write_reg_addr), .data_w(data_w),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    @(negedge clk_in);
    mem_ack = 0;
    if (dec_su) begin sp = sp - 16'd1; n_dec++; end
    if (inc_su) begin sp = sp + 16'd1; n_inc++; end
    if (write_reg) rlog.push_back({write_reg_addr, data_w});
    if (done) n_done++;
    if (mem_req) n_req++;
    if (mem_req && !silent) begin
      if (!inreq) begin
        inreq = 1;
        wcnt = 0;
        dly = $urandom_range(dmax, dmin);
        snap = {mem_we, mem_addr, mem_wdata};
      end else check("req_hold", {mem_we, mem_addr, mem_wdata}, snap);
      if (wcnt == dly) begin
        mem_ack = 1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wlog.push_back({mem_addr, mem_wdata});
        end
        inreq = 0;
      end else wcnt++;
    end else inreq = 0;
  end

  task automatic run(input bit pl, input bit ss, input logic [7:0] mk, input logic [15:0] sp0,
                     input bit inject, output int cyc);
    logic [23:0] ew [$];
    logic [19:0] er [$];
    logic [15:0] v, s, s1;
    int cd [8];
    int nb;
    cd = '{10, 8, 9, 11, 1, 2, 3, 5};
    cd[6] = ss ? 3 : 4;
    s = sp0;
    nb = 0;
    if (!pl) begin
      for (int b = 7; b >= 0; b--) if (mk[3'(b)]) begin
        v = regs[cd[b]];
        s = s - 16'd1;
        ew.push_back({s, v[7:0]});
        if (b >= 4) begin
          s = s - 16'd1;
          ew.push_back({s, v[15:8]});
        end
      end
    end else begin
      for (int b = 0; b < 8; b++) if (mk[3'(b)]) begin
        s1 = s + 16'd1;
        if (b >= 4) begin
          v = {mem[s], mem[s1]};
          s = s + 16'd2;
          nb += 2;
        end else begin
          v = {8'h00, mem[s]};
          s = s1;
          nb += 1;
        end
        er.push_back({4'(cd[b]), v});
      end
    end
    sp = sp0;
    wlog.delete();
    rlog.delete();
    n_dec = 0; n_inc = 0; n_done = 0; n_req = 0;
    is_pull = pl; stack_s = ss; postbyte = mk; start = 1;
    @(negedge clk_in); #1;
    start = 0;
    cyc = 1;
    check("busy_rise", busy, 1);
    while (n_done == 0 && cyc < 1000) begin
      @(negedge clk_in); #1;
      cyc++;
      start = inject && mem_req && $urandom_range(3, 0) == 0;
      if (start) begin
        postbyte = 8'($urandom);
        is_pull = 1'($urandom);
      end
    end
    start = 0;
    check("done_seen", n_done != 0, 1);
    repeat (3) begin @(negedge clk_in); #1; end
    check("done_once", n_done, 1);
    check("n_mem_writes", wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++) check("mem_write", wlog[i], ew[i]);
    check("n_reg_writes", rlog.size(), er.size());
    for (int i = 0; i < er.size() && i < rlog.size(); i++) check("reg_write", rlog[i], er[i]);
    check("final_sp", sp, s);
    check("dec_cnt", n_dec, pl ? 0 : ew.size());
    check("inc_cnt", n_inc, nb);
  endtask

  initial begin
    int cyc, rc, k;
    for (int i = 0; i < 16; i++) regs[i] = i < 8 ? 16'($urandom) : {8'h00, 8'($urandom)};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk_in);
    #1;
    check("reset_outs", outs, 0);
    reset = 0;
    @(negedge clk_in); #1;
    dmin = 0; dmax = 0;
    run(0, 1, 8'hFF, 16'h0F00, 0, cyc);
    check("push_ff_sp", sp, 16'h0EF4);
    check("push_ff_pc_lo", wlog[0], {16'h0EFF, regs[5][7:0]});
    check("push_ff_u_lo", wlog[2], {16'h0EFD, regs[3][7:0]});
    check("push_ff_cc", wlog[11], {16'h0EF4, regs[10][7:0]});
    mem[16'h0EF4] = 8'h11;
    mem[16'h0EF5] = 8'h22;
    run(1, 1, 8'h06, 16'h0EF4, 0, cyc);
    check("pull_a", rlog[0], {4'd8, 16'h0011});
    check("pull_b", rlog[1], {4'd9, 16'h0022});
    check("pull_ab_sp", sp, 16'h0EF6);
    mem[16'h0500] = 8'h12;
    mem[16'h0501] = 8'h34;
    run(1, 0, 8'h80, 16'h0500, 0, cyc);
    check("pull_pc_n", rlog.size(), 1);
    check("pull_pc", rlog[0], {4'd5, 16'h1234});
    run(0, 0, 8'h00, 16'h1234, 0, cyc);
    check("empty_latency", cyc, 3);
    check("empty_no_req", n_req, 0);
    dmin = 4; dmax = 4;
    run(0, 0, 8'h90, 16'h1000, 1, cyc);
    run(1, 1, 8'hC3, 16'h2000, 1, cyc);
    dmin = 0;
    repeat (40) begin
      dmax = $urandom_range(4, 0);
      run(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), cyc);
    end
    silent = 1;
    sp = 16'h2000; is_pull = 0; stack_s = 0; postbyte = 8'h01; n_done = 0; start = 1;
    @(negedge clk_in); #1;
    start = 0;
    rc = 0; k = 0;
    while (!err && k < 100) begin
      if (mem_req) rc++;
      @(negedge clk_in); #1;
      k++;
    end
    check("to_err", err, 1);
    check("to_req_cycles", rc, 8);
    check("to_busy", busy, 0);
    check("to_req_drop", mem_req, 0);
    repeat (3) begin @(negedge clk_in); #1; end
    check("to_no_done", n_done, 0);
    check("to_err_pulse", err, 0);
    silent = 0;
    dmin = 0; dmax = 0;
    sp = 16'h3000; wlog.delete(); is_pull = 0; stack_s = 0; postbyte = 8'hFF; start = 1;
    @(negedge clk_in); #1;
    start = 0;
    k = 0;
    while (wlog.size() < 2 && k < 100) begin @(negedge clk_in); #1; k++; end
    check("rst_reach", wlog.size(), 2);
    repeat (2) begin @(negedge clk_in); #1; end
    check("rst_in_byte3", dec_su, 1);
    reset = 1;
    @(negedge clk_in); #1;
    check("rst_mid_outs", outs, 0);
    reset = 0;
    @(negedge clk_in); #1;
    check("rst_mid_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
